pipeline_sequencer: RTL and testbench
=====================================

Name: pipeline_sequencer

Overview:
Central hazard and interrupt controller for the 5-stage CPU datapath. It takes stall, branch, return, halt and exception requests from decode, plus external interrupt requests. It drives the fetch-stage PC source select, the fetch/decode stall lines, and the instruction-word injection path: NOP for branch flush, synthetic CALL for interrupt entry. It tracks interrupt-in-service state until the retiring RETI is seen at MEM/WB.

Parameters:
NUM_IRQ, 4, number of external interrupt sources; index 0 is highest priority
VECTOR_BASE, 14'h0010, program address of the IRQ 0 vector
VECTOR_STRIDE, 14'h0004, address spacing between consecutive IRQ vectors
EXC_VECTOR, 14'h0008, illegal-opcode exception vector
NOP_WORD, 32'h0000_0000, instruction word injected to flush a wrong-path fetch
CALL_OPCODE, 8'h40, opcode used for the synthetic interrupt call
RET_OPCODE, 8'h41, opcode of RET/RETI as seen at MEM/WB

Ports:
clock  in  1  system clock
nreset  in  1  asynchronous active-low reset
stall_fetch_req  in  1  decode requests fetch hold
stall_decode_req  in  1  decode requests decode hold
halt  in  1  HALT instruction decoded
take_branch_target  in  1  decode resolved a taken branch/jump/call
illegal_opcode_exception  in  1  decode saw an undefined opcode
return_in_pipeline  in  1  RET/RETI between decode and MEM/WB
mem_wb_opcode  in  8  opcode in MEM/WB
mem_wb_reti_bit  in  1  RETI flag (instruction bit 20) in MEM/WB
irq_req  in  NUM_IRQ  level-sensitive interrupt requests
irq_global_en  in  1  global interrupt enable (from SFR)
stall_fetch  out  1  hold PC and IF/ID
stall_decode  out  1  hold ID/EX
hazard_prog_cntr_sel  out  4  PC source select
inst_word_sel  out  1  1 = IF/ID loads hazard_inst_word
hazard_inst_word  out  32  injected instruction word
prog_cntr_int_addr  out  14  interrupt/exception target address
irq_ack  out  NUM_IRQ  one-hot, one-cycle acknowledge of the accepted IRQ
in_service  out  1  an interrupt/exception handler is active
halted  out  1  core is in HALTED state

Behaviour:
- Reset is asynchronous and active-low. On reset the FSM enters RUN, in_service=0, and all outputs are 0 except hazard_prog_cntr_sel=PC_INC.
- PC_SEL encodings: PC_INC=0, PC_BRANCH=1, PC_INT=2, PC_RET=3, PC_HOLD=4.
- Outputs are combinational from state and inputs; state updates on the rising edge of clock.
- Hazard priority, evaluated each cycle in RUN: exception > return > branch > irq > stall request.
- RUN:
  - stall_fetch = stall_fetch_req; stall_decode = stall_decode_req; pc_sel = PC_INC, or PC_HOLD when stall_fetch.
  - illegal_opcode_exception -> pc_sel=PC_INT, prog_cntr_int_addr=EXC_VECTOR, inject the CALL word, set in_service, go to INJECT. Accepted regardless of in_service.
  - return_in_pipeline -> go to RET_WAIT, with stall_fetch=1 in the same cycle.
  - take_branch_target -> pc_sel=PC_BRANCH, inst_word_sel=1, hazard_inst_word=NOP_WORD for exactly one cycle. Stay in RUN.
  - Interrupt accept condition: any irq_req, irq_global_en=1, in_service=0, no higher-priority event, stall_fetch_req=0.
    - Lowest set index k wins.
    - prog_cntr_int_addr = VECTOR_BASE + k*VECTOR_STRIDE, computed in 14 bits; wrap-around is ignored.
    - pc_sel=PC_INT, irq_ack[k]=1, in_service set, go to INJECT.
  - halt -> go to HALTED, with stall_fetch=stall_decode=1.
- INJECT (1 cycle): inst_word_sel=1, hazard_inst_word={int_addr_reg[13:0], 10'b0, CALL_OPCODE}. The CALL then flows down the pipe and pushes the return address. Next state is RUN.
- RET_WAIT:
  - stall_fetch=1 and pc_sel=PC_HOLD each cycle, until mem_wb_opcode==RET_OPCODE.
  - In that cycle pc_sel=PC_RET, stall_fetch=0, and the FSM returns to RUN.
  - If mem_wb_reti_bit=1 in that cycle, in_service is cleared.
  - Exceptions arriving during RET_WAIT are deferred until RUN.
- HALTED:
  - halted=1, stall_fetch=stall_decode=1.
  - Exit when an interrupt accept condition holds; in_service and irq_global_en are evaluated as in RUN. Exit performs the same accept actions via INJECT.
  - If irq_global_en=0, the core stays halted until reset.
- Simultaneous events:
  - Branch with irq pending: the branch is taken and the irq is deferred one cycle.
  - Exception with branch: the exception wins and the branch is discarded.
  - irq_req deasserting before accept: no ack is issued.
- Reset mid-operation (e.g. in RET_WAIT or INJECT) returns to RUN with in_service=0, no residual stall.

Decomposition:
- Shared package: PC_SEL encodings, FSM state enum, CALL/RET opcode constants, NOP_WORD. The datapath fetch stage must use the same PC_SEL constants.
- One sub-module: irq_priority_enc (NUM_IRQ -> valid, index, one-hot), purely combinational.

Test Plan:
- Reset held low mid-RET_WAIT -> stall_fetch=0, pc_sel=0, in_service=0 within the same cycle, not waiting for a clock edge.
- take_branch_target pulse -> one cycle of pc_sel=1, inst_word_sel=1, hazard_inst_word=0; cycle after: pc_sel=0, inst_word_sel=0.
- irq_req=4'b0110, irq_global_en=1 -> irq_ack=4'b0010, int_addr=14'h0014, pc_sel=2; next cycle hazard_inst_word=32'h0050_0040; in_service=1, and a second irq is not accepted.
- RETI flow: return_in_pipeline=1 for 3 cycles, then mem_wb_opcode=8'h41 with reti_bit=1 -> stall_fetch high until that cycle, pc_sel=3 then, in_service cleared next cycle.
- halt=1 then irq_req=4'b1000 after 10 cycles -> halted=1 for 10 cycles; wake with irq_ack=4'b1000, int_addr=14'h001C.
- illegal_opcode_exception with take_branch_target in the same cycle -> pc_sel=2, int_addr=14'h0008, no NOP injection; accepted even with in_service=1.

Source files
------------

// File: rtl/pipeline_sequencer_pkg.sv
// Shared definitions for the pipeline sequencer and the fetch stage that consumes pc_sel.
package pipeline_sequencer_pkg;

    typedef enum logic [3:0] {
        PC_INC    = 4'd0,
        PC_BRANCH = 4'd1,
        PC_INT    = 4'd2,
        PC_RET    = 4'd3,
        PC_HOLD   = 4'd4
    } pc_sel_e;

    typedef enum logic [1:0] {
        SEQ_RUN      = 2'd0,
        SEQ_INJECT   = 2'd1,
        SEQ_RET_WAIT = 2'd2,
        SEQ_HALTED   = 2'd3
    } seq_state_e;

    localparam logic [7:0]  CALL_OPCODE = 8'h40;
    localparam logic [7:0]  RET_OPCODE  = 8'h41;
    localparam logic [31:0] NOP_WORD    = 32'h0000_0000;

    // Interrupt vector for a source index; 14-bit arithmetic, wrap-around ignored.
    function automatic logic [13:0] irq_vector(input logic [13:0] base,
                                               input logic [13:0] stride,
                                               input logic [13:0] idx);
        return base + stride * idx;
    endfunction

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Decode/datapath <-> sequencer signal bundle. master = datapath side, slave = sequencer.
interface pipeline_sequencer_if #(
    parameter int NUM_IRQ = 4
);
    logic               stall_fetch_req;
    logic               stall_decode_req;
    logic               halt;
    logic               take_branch_target;
    logic               illegal_opcode_exception;
    logic               return_in_pipeline;
    logic [7:0]         mem_wb_opcode;
    logic               mem_wb_reti_bit;
    logic [NUM_IRQ-1:0] irq_req;
    logic               irq_global_en;

    logic               stall_fetch;
    logic               stall_decode;
    logic [3:0]         hazard_prog_cntr_sel;
    logic               inst_word_sel;
    logic [31:0]        hazard_inst_word;
    logic [13:0]        prog_cntr_int_addr;
    logic [NUM_IRQ-1:0] irq_ack;
    logic               in_service;
    logic               halted;

    modport master (
        output stall_fetch_req, stall_decode_req, halt, take_branch_target,
               illegal_opcode_exception, return_in_pipeline, mem_wb_opcode,
               mem_wb_reti_bit, irq_req, irq_global_en,
        input  stall_fetch, stall_decode, hazard_prog_cntr_sel, inst_word_sel,
               hazard_inst_word, prog_cntr_int_addr, irq_ack, in_service, halted
    );

    modport slave (
        input  stall_fetch_req, stall_decode_req, halt, take_branch_target,
               illegal_opcode_exception, return_in_pipeline, mem_wb_opcode,
               mem_wb_reti_bit, irq_req, irq_global_en,
        output stall_fetch, stall_decode, hazard_prog_cntr_sel, inst_word_sel,
               hazard_inst_word, prog_cntr_int_addr, irq_ack, in_service, halted
    );

endinterface

// File: rtl/pipeline_sequencer_irq_priority_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module irq_priority_enc #(
    parameter int NUM_IRQ = 4,
    parameter int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               valid,
    output logic [IDX_W-1:0]   index,
    output logic [NUM_IRQ-1:0] onehot
);

    // Scan from the top so the lowest set bit is the last (and winning) assignment.
    always_comb begin
        valid  = |req;
        index  = '0;
        onehot = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                index     = IDX_W'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// Hazard and interrupt sequencer for the 5-stage datapath.
//
// state        | meaning
// -------------+--------------------------------------------------------
// SEQ_RUN      | normal flow; resolves exception/return/branch/irq/halt
// SEQ_INJECT   | one cycle: IF/ID loads synthetic CALL to int_addr_reg
// SEQ_RET_WAIT | fetch held until RET/RETI reaches MEM/WB
// SEQ_HALTED   | core stopped; only an accepted interrupt wakes it
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int          NUM_IRQ       = 4,
    parameter logic [13:0] VECTOR_BASE   = 14'h0010,
    parameter logic [13:0] VECTOR_STRIDE = 14'h0004,
    parameter logic [13:0] EXC_VECTOR    = 14'h0008
) (
    input  logic                clock,
    input  logic                nreset,
    pipeline_sequencer_if.slave bus
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    seq_state_e         state, state_nxt;
    logic               in_service, in_service_nxt;
    logic [13:0]        int_addr_reg, int_addr_nxt;

    logic               irq_valid;
    logic [IDX_W-1:0]   irq_idx;
    logic [NUM_IRQ-1:0] irq_onehot;
    logic               irq_accept;
    logic [13:0]        irq_addr;

    logic               stall_fetch_c;
    logic               stall_decode_c;
    pc_sel_e            pc_sel_c;
    logic               inst_word_sel_c;
    logic [31:0]        inst_word_c;
    logic [13:0]        int_addr_c;
    logic [NUM_IRQ-1:0] irq_ack_c;
    logic               halted_c;

    irq_priority_enc #(
        .NUM_IRQ (NUM_IRQ),
        .IDX_W   (IDX_W)
    ) u_irq_priority_enc (
        .req    (bus.irq_req),
        .valid  (irq_valid),
        .index  (irq_idx),
        .onehot (irq_onehot)
    );

    // A fetch hold request blocks interrupt entry so the vector redirect is never lost.
    assign irq_accept = irq_valid && bus.irq_global_en && !in_service && !bus.stall_fetch_req;
    assign irq_addr   = irq_vector(VECTOR_BASE, VECTOR_STRIDE, 14'(irq_idx));

    // Next-state and output decode; reset forces outputs idle without waiting for an edge.
    always_comb begin
        state_nxt       = state;
        in_service_nxt  = in_service;
        int_addr_nxt    = int_addr_reg;
        stall_fetch_c   = 1'b0;
        stall_decode_c  = 1'b0;
        pc_sel_c        = PC_INC;
        inst_word_sel_c = 1'b0;
        inst_word_c     = NOP_WORD;
        int_addr_c      = '0;
        irq_ack_c       = '0;
        halted_c        = 1'b0;

        case (state)
            SEQ_RUN: begin
                stall_fetch_c  = bus.stall_fetch_req;
                stall_decode_c = bus.stall_decode_req;
                pc_sel_c       = bus.stall_fetch_req ? PC_HOLD : PC_INC;
                if (bus.illegal_opcode_exception) begin
                    // Exceptions ignore in_service: a faulting handler must still trap.
                    stall_fetch_c  = 1'b0;
                    stall_decode_c = 1'b0;
                    pc_sel_c       = PC_INT;
                    int_addr_c     = EXC_VECTOR;
                    int_addr_nxt   = EXC_VECTOR;
                    in_service_nxt = 1'b1;
                    state_nxt      = SEQ_INJECT;
                end else if (bus.return_in_pipeline) begin
                    stall_fetch_c = 1'b1;
                    pc_sel_c      = PC_HOLD;
                    state_nxt     = SEQ_RET_WAIT;
                end else if (bus.take_branch_target) begin
                    stall_fetch_c   = 1'b0;
                    stall_decode_c  = 1'b0;
                    pc_sel_c        = PC_BRANCH;
                    inst_word_sel_c = 1'b1;
                    inst_word_c     = NOP_WORD;
                end else if (irq_accept) begin
                    pc_sel_c       = PC_INT;
                    int_addr_c     = irq_addr;
                    int_addr_nxt   = irq_addr;
                    irq_ack_c      = irq_onehot;
                    in_service_nxt = 1'b1;
                    state_nxt      = SEQ_INJECT;
                end else if (bus.halt) begin
                    stall_fetch_c  = 1'b1;
                    stall_decode_c = 1'b1;
                    pc_sel_c       = PC_HOLD;
                    state_nxt      = SEQ_HALTED;
                end
            end

            SEQ_INJECT: begin
                inst_word_sel_c = 1'b1;
                inst_word_c     = {int_addr_reg, 10'b0, CALL_OPCODE};
                int_addr_c      = int_addr_reg;
                state_nxt       = SEQ_RUN;
            end

            SEQ_RET_WAIT: begin
                stall_fetch_c = 1'b1;
                pc_sel_c      = PC_HOLD;
                if (bus.mem_wb_opcode == RET_OPCODE) begin
                    stall_fetch_c = 1'b0;
                    pc_sel_c      = PC_RET;
                    state_nxt     = SEQ_RUN;
                    if (bus.mem_wb_reti_bit) begin
                        in_service_nxt = 1'b0;
                    end
                end
            end

            SEQ_HALTED: begin
                halted_c       = 1'b1;
                stall_fetch_c  = 1'b1;
                stall_decode_c = 1'b1;
                pc_sel_c       = PC_HOLD;
                if (irq_accept) begin
                    stall_fetch_c  = 1'b0;
                    stall_decode_c = 1'b0;
                    pc_sel_c       = PC_INT;
                    int_addr_c     = irq_addr;
                    int_addr_nxt   = irq_addr;
                    irq_ack_c      = irq_onehot;
                    in_service_nxt = 1'b1;
                    state_nxt      = SEQ_INJECT;
                end
            end

            default: begin
                state_nxt = SEQ_RUN;
            end
        endcase

        if (!nreset) begin
            stall_fetch_c   = 1'b0;
            stall_decode_c  = 1'b0;
            pc_sel_c        = PC_INC;
            inst_word_sel_c = 1'b0;
            inst_word_c     = NOP_WORD;
            int_addr_c      = '0;
            irq_ack_c       = '0;
            halted_c        = 1'b0;
        end
    end

    // State, in-service flag and latched target address.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state        <= SEQ_RUN;
            in_service   <= 1'b0;
            int_addr_reg <= '0;
        end else begin
            state        <= state_nxt;
            in_service   <= in_service_nxt;
            int_addr_reg <= int_addr_nxt;
        end
    end

    assign bus.stall_fetch          = stall_fetch_c;
    assign bus.stall_decode         = stall_decode_c;
    assign bus.hazard_prog_cntr_sel = pc_sel_c;
    assign bus.inst_word_sel        = inst_word_sel_c;
    assign bus.hazard_inst_word     = inst_word_c;
    assign bus.prog_cntr_int_addr   = int_addr_c;
    assign bus.irq_ack              = irq_ack_c;
    assign bus.in_service           = in_service;
    assign bus.halted               = halted_c;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: expectations queued with stimulus, drained at sample time.
module tb_pipeline_sequencer;

    localparam int F_SF   = 0;
    localparam int F_SD   = 1;
    localparam int F_PC   = 2;
    localparam int F_ISEL = 3;
    localparam int F_WORD = 4;
    localparam int F_ADDR = 5;
    localparam int F_ACK  = 6;
    localparam int F_INS  = 7;
    localparam int F_HLT  = 8;

    typedef struct {
        int          fld;
        logic [31:0] val;
        string       tag;
    } exp_t;

    logic clock;
    logic nreset;
    int   n_chk;
    int   n_pass;
    exp_t sb[$];

    pipeline_sequencer_if #(.NUM_IRQ(4)) bus ();

    pipeline_sequencer dut (
        .clock  (clock),
        .nreset (nreset),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] observe(input int fld);
        case (fld)
            F_SF:    return {31'b0, bus.stall_fetch};
            F_SD:    return {31'b0, bus.stall_decode};
            F_PC:    return {28'b0, bus.hazard_prog_cntr_sel};
            F_ISEL:  return {31'b0, bus.inst_word_sel};
            F_WORD:  return bus.hazard_inst_word;
            F_ADDR:  return {18'b0, bus.prog_cntr_int_addr};
            F_ACK:   return {28'b0, bus.irq_ack};
            F_INS:   return {31'b0, bus.in_service};
            F_HLT:   return {31'b0, bus.halted};
            default: return 32'hdead_beef;
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic push_exp(input int fld, input logic [31:0] val, input string tag);
        exp_t e;
        e.fld = fld;
        e.val = val;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_val(e.tag, observe(e.fld), e.val);
        end
    endtask

    task automatic settle();
        #2;
        drain();
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        bus.stall_fetch_req          = 1'b0;
        bus.stall_decode_req         = 1'b0;
        bus.halt                     = 1'b0;
        bus.take_branch_target       = 1'b0;
        bus.illegal_opcode_exception = 1'b0;
        bus.return_in_pipeline       = 1'b0;
        bus.mem_wb_opcode            = 8'h00;
        bus.mem_wb_reti_bit          = 1'b0;
        bus.irq_req                  = 4'b0000;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        nreset = 1'b0;
        clear_inputs();
        bus.irq_global_en      = 1'b1;
        bus.return_in_pipeline = 1'b1;
        bus.halt               = 1'b1;
        @(negedge clock);

        push_exp(F_SF,   0, "rst_sf");
        push_exp(F_SD,   0, "rst_sd");
        push_exp(F_PC,   0, "rst_pc");
        push_exp(F_ISEL, 0, "rst_isel");
        push_exp(F_WORD, 0, "rst_word");
        push_exp(F_ADDR, 0, "rst_addr");
        push_exp(F_ACK,  0, "rst_ack");
        push_exp(F_INS,  0, "rst_ins");
        push_exp(F_HLT,  0, "rst_hlt");
        settle();

        nreset = 1'b1;
        clear_inputs();
        push_exp(F_PC, 0, "idle_pc");
        settle();

        // branch flush
        bus.take_branch_target = 1'b1;
        push_exp(F_PC, 1, "br_pc"); push_exp(F_ISEL, 1, "br_isel");
        push_exp(F_WORD, 0, "br_word"); push_exp(F_SF, 0, "br_sf");
        settle();
        bus.take_branch_target = 1'b0;
        push_exp(F_PC, 0, "br_after_pc"); push_exp(F_ISEL, 0, "br_after_isel");
        settle();

        // interrupt entry, priority among 4'b0110
        bus.irq_req = 4'b0110;
        push_exp(F_ACK, 4'b0010, "irq_ack"); push_exp(F_ADDR, 14'h0014, "irq_addr");
        push_exp(F_PC, 2, "irq_pc"); push_exp(F_ISEL, 0, "irq_isel");
        settle();
        push_exp(F_ISEL, 1, "inj_isel"); push_exp(F_WORD, 32'h0050_0040, "inj_word");
        push_exp(F_ACK, 0, "inj_ack"); push_exp(F_INS, 1, "inj_ins");
        settle();
        push_exp(F_ACK, 0, "nested_ack"); push_exp(F_PC, 0, "nested_pc"); push_exp(F_INS, 1, "nested_ins");
        settle();
        bus.irq_req = 4'b0000;

        // RETI flow with a deferred exception during RET_WAIT
        bus.return_in_pipeline = 1'b1;
        push_exp(F_SF, 1, "ret0_sf"); push_exp(F_PC, 4, "ret0_pc");
        settle();
        bus.illegal_opcode_exception = 1'b1;
        push_exp(F_SF, 1, "ret1_sf"); push_exp(F_PC, 4, "ret1_exc_deferred_pc"); push_exp(F_ISEL, 0, "ret1_isel");
        settle();
        bus.illegal_opcode_exception = 1'b0;
        push_exp(F_SF, 1, "ret2_sf"); push_exp(F_PC, 4, "ret2_pc");
        settle();
        bus.return_in_pipeline = 1'b0;
        bus.mem_wb_opcode      = 8'h41;
        bus.mem_wb_reti_bit    = 1'b1;
        push_exp(F_PC, 3, "reti_pc"); push_exp(F_SF, 0, "reti_sf"); push_exp(F_INS, 1, "reti_ins_still");
        settle();
        bus.mem_wb_opcode   = 8'h00;
        bus.mem_wb_reti_bit = 1'b0;
        push_exp(F_INS, 0, "reti_ins_clr"); push_exp(F_PC, 0, "reti_after_pc"); push_exp(F_SF, 0, "reti_after_sf");
        settle();

        // branch with pending irq: irq deferred one cycle
        bus.irq_req            = 4'b0001;
        bus.take_branch_target = 1'b1;
        push_exp(F_PC, 1, "brirq_pc"); push_exp(F_ACK, 0, "brirq_ack"); push_exp(F_ISEL, 1, "brirq_isel");
        settle();
        bus.take_branch_target = 1'b0;
        push_exp(F_ACK, 4'b0001, "irq0_ack"); push_exp(F_ADDR, 14'h0010, "irq0_addr"); push_exp(F_PC, 2, "irq0_pc");
        settle();
        bus.irq_req = 4'b0000;
        push_exp(F_WORD, 32'h0040_0040, "irq0_word"); push_exp(F_ISEL, 1, "irq0_isel");
        settle();

        // exception + branch while in service
        bus.illegal_opcode_exception = 1'b1;
        bus.take_branch_target       = 1'b1;
        push_exp(F_PC, 2, "exc_pc"); push_exp(F_ADDR, 14'h0008, "exc_addr");
        push_exp(F_ISEL, 0, "exc_isel"); push_exp(F_INS, 1, "exc_ins");
        settle();
        bus.illegal_opcode_exception = 1'b0;
        bus.take_branch_target       = 1'b0;
        push_exp(F_WORD, 32'h0020_0040, "exc_word"); push_exp(F_ISEL, 1, "exc_inj_isel");
        settle();
        bus.return_in_pipeline = 1'b1;
        push_exp(F_SF, 1, "ret_b_sf");
        settle();
        bus.return_in_pipeline = 1'b0;
        bus.mem_wb_opcode      = 8'h41;
        bus.mem_wb_reti_bit    = 1'b1;
        push_exp(F_PC, 3, "ret_b_pc");
        settle();
        bus.mem_wb_opcode   = 8'h00;
        bus.mem_wb_reti_bit = 1'b0;

        // irq blocked by fetch stall, withdrawn before accept
        bus.stall_fetch_req = 1'b1;
        bus.irq_req         = 4'b0001;
        push_exp(F_ACK, 0, "stl_ack"); push_exp(F_PC, 4, "stl_pc"); push_exp(F_SF, 1, "stl_sf"); push_exp(F_INS, 0, "stl_ins");
        settle();
        bus.stall_fetch_req = 1'b0;
        bus.irq_req         = 4'b0000;
        push_exp(F_ACK, 0, "wd_ack"); push_exp(F_PC, 0, "wd_pc");
        settle();

        // halt, then wake by irq 3
        bus.halt = 1'b1;
        push_exp(F_SF, 1, "halt_sf"); push_exp(F_SD, 1, "halt_sd");
        settle();
        bus.halt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            push_exp(F_HLT, 1, "hlt_halted"); push_exp(F_SF, 1, "hlt_sf");
            push_exp(F_SD, 1, "hlt_sd"); push_exp(F_ACK, 0, "hlt_ack");
            settle();
        end
        bus.irq_req = 4'b1000;
        push_exp(F_ACK, 4'b1000, "wake_ack"); push_exp(F_ADDR, 14'h001C, "wake_addr");
        push_exp(F_PC, 2, "wake_pc"); push_exp(F_HLT, 1, "wake_hlt");
        settle();
        bus.irq_req = 4'b0000;
        push_exp(F_HLT, 0, "wake_inj_hlt"); push_exp(F_WORD, 32'h0070_0040, "wake_word"); push_exp(F_INS, 1, "wake_ins");
        settle();

        // halted with global enable off stays halted
        nreset = 1'b0;
        #1;
        nreset = 1'b1;
        @(negedge clock);
        bus.irq_global_en = 1'b0;
        bus.halt          = 1'b1;
        settle();
        bus.halt    = 1'b0;
        bus.irq_req = 4'b0001;
        for (int i = 0; i < 2; i++) begin
            push_exp(F_HLT, 1, "gdis_hlt"); push_exp(F_ACK, 0, "gdis_ack");
            settle();
        end
        nreset            = 1'b0;
        bus.irq_req       = 4'b0000;
        bus.irq_global_en = 1'b1;
        push_exp(F_HLT, 0, "gdis_rst_hlt");
        settle();
        nreset = 1'b1;
        @(negedge clock);

        // async reset in RET_WAIT with in_service set
        bus.illegal_opcode_exception = 1'b1;
        settle();
        bus.illegal_opcode_exception = 1'b0;
        settle();
        bus.return_in_pipeline = 1'b1;
        settle();
        push_exp(F_SF, 1, "rw_pre_sf"); push_exp(F_INS, 1, "rw_pre_ins"); push_exp(F_PC, 4, "rw_pre_pc");
        #2;
        drain();
        #1;
        nreset = 1'b0;
        #1;
        push_exp(F_SF, 0, "rw_rst_sf"); push_exp(F_PC, 0, "rw_rst_pc"); push_exp(F_INS, 0, "rw_rst_ins");
        drain();
        @(negedge clock);
        clear_inputs();
        nreset = 1'b1;
        @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
